// File: rtl/core_pipe_fetch_redirect_pkg.sv
// core_pipe_fetch_redirect_pkg: shared fetch buffer constants and entry width helper.
package core_pipe_fetch_redirect_pkg;
    localparam int FETCH_XL        = 63;
    localparam int FETCH_BUF_DEPTH = 4;
    localparam int FETCH_ENTRY_W   = 32 + 1 + FETCH_XL + 1;

    function automatic int fetch_entry_w(input int xl);
        return 32 + 1 + xl + 1;
    endfunction
endpackage

// File: rtl/core_pipe_fetch_redirect_fifo.sv
// core_pipe_fetch_fifo: synchronous FIFO with push, pop, flush and occupancy count.
module core_pipe_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 97
) (
    input  logic                       g_clk,
    input  logic                       g_resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; count alone decides what is visible.
    always_ff @(posedge g_clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/core_pipe_fetch_redirect.sv
// core_pipe_fetch_redirect: fetch responder that buffers imem words and restarts on an acked redirect.
// Defining CORE_FETCH_REDIRECT_STATS_EN adds saturating stat_redirects/stat_discards counters.
module core_pipe_fetch_redirect
    import core_pipe_fetch_redirect_pkg::*;
#(
    parameter int          XL         = FETCH_XL,
    parameter int          BUF_DEPTH  = FETCH_BUF_DEPTH,
    parameter logic [XL:0] RESET_ADDR = '0
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          cf_valid,
    output logic          cf_ack,
    input  logic [XL:0]   cf_target,
    output logic          imem_req,
    input  logic          imem_gnt,
    output logic [XL:0]   imem_addr,
    input  logic          imem_recv,
    input  logic [31:0]   imem_rdata,
    input  logic          imem_error,
    output logic          s1_valid,
    input  logic          s1_ready,
    output logic [31:0]   s1_data,
    output logic [XL:0]   s1_pc,
    output logic          s1_error
`ifdef CORE_FETCH_REDIRECT_STATS_EN
    ,
    output logic [31:0]   stat_redirects,
    output logic [31:0]   stat_discards
`endif
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int EW = fetch_entry_w(XL);

    logic          active;
    logic [CW-1:0] outstanding, discard, fifo_count, inflight_next;
    logic [CW:0]   occupancy;
    logic [XL:0]   resp_pc;
    logic          grant, drop, push, pop;
    logic [EW-1:0] entry, head;

    // active holds imem_req low for the first cycle out of reset
    assign occupancy     = (CW+1)'(outstanding) + (CW+1)'(fifo_count);
    assign imem_req      = active && (occupancy < (CW+1)'(BUF_DEPTH));
    assign cf_ack        = cf_valid && (!imem_req || imem_gnt);
    assign grant         = imem_req && imem_gnt;
    assign drop          = imem_recv && (discard != '0);
    assign push          = imem_recv && !drop && !cf_ack;
    assign pop           = s1_valid && s1_ready && !cf_ack;
    assign s1_valid      = fifo_count != '0;
    assign inflight_next = outstanding + CW'(grant) - CW'(imem_recv);
    assign entry         = {imem_rdata, imem_error, resp_pc};
    assign {s1_data, s1_error, s1_pc} = head;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            active      <= 1'b0;
            imem_addr   <= {RESET_ADDR[XL:2], 2'b00};
            resp_pc     <= RESET_ADDR;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            active      <= 1'b1;
            outstanding <= inflight_next;
            // every request still in flight after an ack belongs to the old path
            discard     <= cf_ack ? inflight_next : discard - CW'(drop);
            imem_addr   <= cf_ack ? {cf_target[XL:2], 2'b00} :
                           grant  ? imem_addr + (XL+1)'(4) : imem_addr;
            resp_pc     <= cf_ack ? cf_target :
                           push   ? {resp_pc[XL:2], 2'b00} + (XL+1)'(4) : resp_pc;
        end
    end

    core_pipe_fetch_fifo #(.DEPTH(BUF_DEPTH), .W(EW)) u_fifo (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .push     (push),
        .pop      (pop),
        .flush    (cf_ack),
        .wdata    (entry),
        .rdata    (head),
        .count    (fifo_count)
    );

`ifdef CORE_FETCH_REDIRECT_STATS_EN
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            stat_redirects <= '0;
            stat_discards  <= '0;
        end else begin
            if (cf_ack && stat_redirects != '1) stat_redirects <= stat_redirects + 32'd1;
            if (drop && stat_discards != '1) stat_discards <= stat_discards + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_core_pipe_fetch_redirect.sv
// tb_core_pipe_fetch_redirect: directed and randomized checks against a queue-based fetch model.
module tb_core_pipe_fetch_redirect;
    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        cf_valid = 1'b0, cf_ack;
    logic [63:0] cf_target = '0;
    logic        imem_req, imem_gnt = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_recv = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_error = 1'b0;
    logic        s1_valid, s1_ready = 1'b0;
    logic [31:0] s1_data;
    logic [63:0] s1_pc;
    logic        s1_error;
`ifdef CORE_FETCH_REDIRECT_STATS_EN
    logic [31:0] stat_redirects, stat_discards;
`endif

    core_pipe_fetch_redirect dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .cf_valid   (cf_valid),
        .cf_ack     (cf_ack),
        .cf_target  (cf_target),
        .imem_req   (imem_req),
        .imem_gnt   (imem_gnt),
        .imem_addr  (imem_addr),
        .imem_recv  (imem_recv),
        .imem_rdata (imem_rdata),
        .imem_error (imem_error),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .s1_data    (s1_data),
        .s1_pc      (s1_pc),
        .s1_error   (s1_error)
`ifdef CORE_FETCH_REDIRECT_STATS_EN
        ,
        .stat_redirects (stat_redirects),
        .stat_discards  (stat_discards)
`endif
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [63:0] pc;
        bit          live;
    } ent_t;

    // mq: granted requests awaiting a response; fq: words decode should see
    ent_t        mq[$];
    ent_t        fq[$];
    logic [63:0] m_addr, m_pc;
    bit          started, exp_req, exp_ack, rand_err;
    int          ngrants, err_idx = -1;
    int          checks = 0, failures = 0;

    task automatic hold_reset();
        @(negedge g_clk);
        g_resetn = 1'b0;
        cf_valid = 1'b0; imem_gnt = 1'b0; imem_recv = 1'b0; s1_ready = 1'b0;
        mq.delete(); fq.delete();
        m_addr = '0; m_pc = '0; started = 1'b0; ngrants = 0; rand_err = 1'b0;
        repeat (2) @(negedge g_clk);
    endtask

    task automatic reset_dut();
        hold_reset();
        g_resetn = 1'b1;
    endtask

    task automatic drive(input bit cfv, input logic [63:0] tgt, input bit gnt, input bit rcv, input bit rdy);
        cf_valid = cfv; cf_target = tgt; imem_gnt = gnt; s1_ready = rdy;
        imem_recv = rcv && (mq.size() != 0);
        imem_rdata = 32'hdead_beef; imem_error = 1'b0;
        if (mq.size() != 0) begin
            imem_rdata = mq[0].data;
            imem_error = mq[0].err;
        end
        exp_req = started && (mq.size() + fq.size() < 4);
        exp_ack = cfv && (!exp_req || gnt);
        #1;
    endtask

    task automatic advance();
        bit   grant, pop;
        ent_t r;
        @(posedge g_clk);
        grant = exp_req && imem_gnt;
        pop = (fq.size() != 0) && s1_ready && !exp_ack;
        if (pop) void'(fq.pop_front());
        if (imem_recv) begin
            r = mq.pop_front();
            if (r.live && !exp_ack) fq.push_back(r);
        end
        if (exp_ack) begin
            fq.delete();
            foreach (mq[i]) mq[i].live = 1'b0;
        end
        if (grant) begin
            r.data = $urandom;
            r.err  = (ngrants == err_idx) || (rand_err && $urandom_range(0, 3) == 0);
            r.pc   = m_pc;
            r.live = !exp_ack;
            mq.push_back(r);
            m_addr = m_addr + 64'd4;
            m_pc   = m_addr;
            ngrants++;
        end
        if (exp_ack) begin
            m_addr = {cf_target[63:2], 2'b00};
            m_pc   = cf_target;
        end
        started = 1'b1;
        @(negedge g_clk);
    endtask

    task automatic test_reset();
        hold_reset();
        #1;
        checks++; if (cf_ack !== 1'b0) begin failures++; $display("FAIL reset_cf_ack got=%b exp=0", cf_ack); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got=%b exp=0", imem_req); end
        checks++; if (s1_valid !== 1'b0) begin failures++; $display("FAIL reset_s1_valid got=%b exp=0", s1_valid); end
        checks++; if (imem_addr !== 64'h0) begin failures++; $display("FAIL reset_imem_addr got=%h exp=0", imem_addr); end
        g_resetn = 1'b1;
    endtask

    task automatic test_stream();
        int ga = 0, pi = 0;
        reset_dut();
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
            checks++; if (imem_req !== exp_req) begin failures++; $display("FAIL stream_req cyc=%0d got=%b exp=%b", c, imem_req, exp_req); end
            if (imem_req && imem_gnt && ga < 4) begin
                checks++; if (imem_addr !== 64'(ga * 4)) begin failures++; $display("FAIL stream_addr got=%h exp=%h", imem_addr, 64'(ga * 4)); end
                ga++;
            end
            if (s1_valid && pi < 3) begin
                checks++; if (s1_pc !== 64'(pi * 4)) begin failures++; $display("FAIL stream_pc got=%h exp=%h", s1_pc, 64'(pi * 4)); end
                pi++;
            end
            advance();
        end
        checks++; if (ga != 4 || pi != 3) begin failures++; $display("FAIL stream_count got=%0d/%0d exp=4/3", ga, pi); end
    endtask

    task automatic test_backpressure();
        int g = 0;
        reset_dut();
        for (int c = 0; c < 14; c++) begin
            drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
            checks++; if (imem_req !== exp_req) begin failures++; $display("FAIL bp_req cyc=%0d got=%b exp=%b", c, imem_req, exp_req); end
            if (imem_req && imem_gnt) g++;
            advance();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (g != 4) begin failures++; $display("FAIL bp_grants got=%0d exp=4", g); end
        checks++; if (s1_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL bp_full got=%b%b exp=10", s1_valid, imem_req); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
            checks++; if (s1_valid !== 1'b1 || s1_pc !== 64'(i * 4)) begin failures++; $display("FAIL bp_drain got=%b/%h exp=1/%h", s1_valid, s1_pc, 64'(i * 4)); end
            advance();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (s1_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", s1_valid); end
    endtask

    task automatic test_redirect();
        logic [63:0] want [2] = '{64'h102, 64'h104};
        int pi = 0;
        bit first_grant = 1'b1;
        reset_dut();
        repeat (5) begin drive(1'b0, '0, 1'b1, 1'b0, 1'b0); advance(); end
        repeat (2) begin drive(1'b0, '0, 1'b0, 1'b1, 1'b0); advance(); end
        drive(1'b1, 64'h102, 1'b0, 1'b0, 1'b0);
        checks++; if (cf_ack !== 1'b1) begin failures++; $display("FAIL redir_ack got=%b exp=1", cf_ack); end
        advance();
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
            if (imem_req && imem_gnt && first_grant) begin
                checks++; if (imem_addr !== 64'h100) begin failures++; $display("FAIL redir_addr got=%h exp=100", imem_addr); end
                first_grant = 1'b0;
            end
            if (s1_valid && pi < 2) begin
                checks++; if (s1_pc !== want[pi]) begin failures++; $display("FAIL redir_pc got=%h exp=%h", s1_pc, want[pi]); end
                pi++;
            end
            advance();
        end
        checks++; if (pi != 2) begin failures++; $display("FAIL redir_words got=%0d exp=2", pi); end
    endtask

    task automatic test_stall();
        reset_dut();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 64'h40, 1'b0, 1'b0, 1'b0);
            checks++; if (cf_ack !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h0) begin
                failures++; $display("FAIL stall_wait got=%b/%b/%h exp=0/1/0", cf_ack, imem_req, imem_addr);
            end
            advance();
        end
        drive(1'b1, 64'h40, 1'b1, 1'b0, 1'b0);
        checks++; if (cf_ack !== 1'b1) begin failures++; $display("FAIL stall_ack got=%b exp=1", cf_ack); end
        advance();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 64'h40) begin failures++; $display("FAIL stall_addr got=%h exp=40", imem_addr); end
    endtask

    task automatic test_error();
        int k = 0;
        reset_dut();
        err_idx = 1;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
            if (s1_valid && k < 4) begin
                checks++; if (s1_error !== (k == 1) || s1_pc !== 64'(k * 4)) begin
                    failures++; $display("FAIL err_word k=%0d got=%b/%h exp=%b/%h", k, s1_error, s1_pc, k == 1, 64'(k * 4));
                end
                k++;
            end
            advance();
        end
        err_idx = -1;
        checks++; if (k != 4) begin failures++; $display("FAIL err_count got=%0d exp=4", k); end
    endtask

    task automatic test_full_redirect();
        bit seen = 1'b0;
        reset_dut();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0); advance();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0); advance();
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0); advance();
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0); advance();
        drive(1'b1, 64'h200, 1'b1, 1'b1, 1'b1);
        checks++; if (cf_ack !== 1'b1 || imem_req !== 1'b1 || imem_recv !== 1'b1) begin
            failures++; $display("FAIL full_ack got=%b/%b/%b exp=1/1/1", cf_ack, imem_req, imem_recv);
        end
        advance();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++; if (s1_valid !== 1'b0) begin failures++; $display("FAIL full_flush got=%b exp=0", s1_valid); end
`ifdef CORE_FETCH_REDIRECT_STATS_EN
        checks++; if (stat_redirects !== 32'd1) begin failures++; $display("FAIL stat_redirects got=%0d exp=1", stat_redirects); end
`endif
        advance();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
            if (s1_valid && !seen) begin
                checks++; if (s1_pc !== 64'h200) begin failures++; $display("FAIL full_pc got=%h exp=200", s1_pc); end
                seen = 1'b1;
            end
            advance();
        end
        checks++; if (!seen) begin failures++; $display("FAIL full_word got=0 exp=1"); end
    endtask

    task automatic test_random();
        reset_dut();
        rand_err = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 7) == 0, {$urandom, $urandom} & ~64'h1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
            checks++; if (cf_ack !== exp_ack) begin failures++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", c, cf_ack, exp_ack); end
            checks++; if (imem_req !== exp_req) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", c, imem_req, exp_req); end
            checks++; if (imem_addr !== m_addr) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, imem_addr, m_addr); end
            checks++; if (s1_valid !== (fq.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, s1_valid, fq.size() != 0); end
            if (fq.size() != 0) begin
                checks++; if (s1_data !== fq[0].data || s1_pc !== fq[0].pc || s1_error !== fq[0].err) begin
                    failures++; $display("FAIL rnd_word cyc=%0d got=%h/%h/%b exp=%h/%h/%b", c, s1_data, s1_pc, s1_error, fq[0].data, fq[0].pc, fq[0].err);
                end
            end
            advance();
        end
        rand_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_stall();
        test_error();
        test_full_redirect();
        test_random();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
